letters_draw: RTL and testbench
===============================

// Module: letters_draw
// PURPOSE
// - Consumer end of the board-label path. bg_letters drives char_addr to the font ROM;
//   this block takes the ROM row data (char_pixels) and paints label glyphs onto the VGA stream.
// - Delays the vga_if timing and rgb so they line up with the ROM read latency.
// - Overlays LETTER_COLOR wherever the addressed glyph bit is set.
// - Sits between the board/figure drawing stage and the next vga_if consumer.
// PARAMETERS
// - ROM_LATENCY   1        clocks from char_addr valid to char_pixels valid (1..4)
// - X_OFFSET      4        hcount offset of glyph column 0 (label origins are 28/236/780, all = 4 mod 8)
// - LETTER_COLOR  12'hFFF  rgb written for set glyph pixels
// PORTS
// - clk          in   1     system pixel clock; single clock domain
// - rst          in   1     reset, asynchronous, active-low
// - char_addr    in   11    {char_code[6:0], line[3:0]} from bg_letters, same cycle as vga_in
// - char_pixels  in   8     font ROM row for char_addr, valid ROM_LATENCY clocks later; bit7 = leftmost
// - vga_in       vga_if.in  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb[11:0]
// - vga_out      vga_if.out same fields, delayed by ROM_LATENCY+1 clocks
// BEHAVIOUR
// - Reset (rst=0, async): all vga_out fields = 0; all pipeline stages = 0.
//   Release: first valid vga_out appears ROM_LATENCY+1 rising edges after release.
// - Pipeline stage k (1..ROM_LATENCY): register all vga_in fields plus draw_en and col.
//   - draw_en = (char_addr[10:4] != 0).
//   - col     = (hcount - X_OFFSET)[2:0], 3-bit wrap-around subtraction.
// - Final stage (the register feeding vga_out), computed from stage ROM_LATENCY and char_pixels:
//   - pix = char_pixels[7 - col].
//   - Blanking (hblnk | vblnk): rgb passes through unchanged.
//   - Else draw_en & pix: rgb = LETTER_COLOR.
//   - Else: rgb = delayed input rgb.
//   - hcount, vcount, hsync, vsync, hblnk and vblnk are always pure delays; they are never modified.
// - Total latency: every vga_out field = vga_in field delayed exactly ROM_LATENCY+1 clocks.
//   No bubbles, no stalls, one pixel per clock.
// - char_addr == 0 (outside label regions): never paints, whatever char_pixels holds.
// - Glyph column wrap: col 7 -> col 0 at the next 8-pixel boundary with no gap;
//   adjacent glyphs are contiguous.
// - Label region touching blanking: blanking wins; no colour is written during blnk.
// - Reset asserted mid-frame: outputs clear at once (async).
//   After release the pipeline refills from the live stream; no stale pixels are emitted.
// - No FSM: fixed-depth shift pipeline. Generate the depth from ROM_LATENCY.
// TESTING
// - Reset: hold rst=0, toggle vga_in -> vga_out all-zero.
//   Release rst -> vga_out.hcount equals vga_in.hcount from 2 clocks earlier (ROM_LATENCY=1).
// - Pass-through: char_addr=0, char_pixels=8'hFF, rgb=12'h0A5 for a full line
//   -> vga_out.rgb = 12'h0A5 on every pixel.
// - Glyph row: char_addr={7'h31,4'h3}, hcount 284..291, ROM model returns 8'b1000_0001
//   -> vga_out.rgb = 12'hFFF only at delayed hcount 284 and 291; other pixels keep input rgb.
// - Blanking priority: draw_en=1, char_pixels=8'hFF, hblnk=1
//   -> vga_out.rgb = delayed input rgb; sync and blank fields delayed exactly 2 clocks.
// - Latency sweep: ROM_LATENCY=3 with a 3-cycle ROM model, same glyph stimulus
//   -> same pixel pattern, shifted by 4 clocks.
// - Mid-frame reset: pulse rst=0 for 3 clocks while painting
//   -> outputs 0 during the pulse; correct glyph pixels resume 2 clocks after release.
//   Scoreboard compares against a frame model.

Source files
------------

// File: rtl/letters_draw.sv
// Font-glyph overlay stage: delays the VGA stream to match the font ROM latency
// and paints LETTER_COLOR wherever the addressed glyph row bit is set.
module letters_draw #(
  parameter int          ROM_LATENCY  = 1,
  parameter int          X_OFFSET     = 4,
  parameter logic [11:0] LETTER_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] char_addr,
  input  logic [7:0]  char_pixels,
  input  logic [10:0] vga_in_hcount,
  input  logic [10:0] vga_in_vcount,
  input  logic        vga_in_hsync,
  input  logic        vga_in_vsync,
  input  logic        vga_in_hblnk,
  input  logic        vga_in_vblnk,
  input  logic [11:0] vga_in_rgb,
  output logic [10:0] vga_out_hcount,
  output logic [10:0] vga_out_vcount,
  output logic        vga_out_hsync,
  output logic        vga_out_vsync,
  output logic        vga_out_hblnk,
  output logic        vga_out_vblnk,
  output logic [11:0] vga_out_rgb
);

  localparam int         W  = 42;
  localparam logic [2:0] XO = 3'(X_OFFSET);

  logic [W-1:0]                  w_in;
  logic [2:0]                    w_col;
  logic                          w_draw_en;
  logic [ROM_LATENCY:1][W-1:0]   r_stage;
  logic [W-1:0]                  w_last;

  logic [10:0] w_hc;
  logic [10:0] w_vc;
  logic        w_hs;
  logic        w_vs;
  logic        w_hb;
  logic        w_vb;
  logic [11:0] w_rgb_d;
  logic        w_en;
  logic [2:0]  w_lcol;
  logic        w_pix;
  logic [11:0] w_rgb;

  logic [10:0] r_hc;
  logic [10:0] r_vc;
  logic        r_hs;
  logic        r_vs;
  logic        r_hb;
  logic        r_vb;
  logic [11:0] r_rgb;

  assign w_col     = vga_in_hcount[2:0] - XO;
  assign w_draw_en = (char_addr[10:4] != 7'd0);
  assign w_in      = {vga_in_hcount, vga_in_vcount,
                      vga_in_hsync, vga_in_vsync,
                      vga_in_hblnk, vga_in_vblnk,
                      vga_in_rgb, w_draw_en, w_col};

  // Depth tracks the ROM read latency so glyph data meets its pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stage <= '0;
    end else begin
      r_stage[1] <= w_in;
      for (int k = 2; k <= ROM_LATENCY; k++)
        r_stage[k] <= r_stage[k-1];
    end
  end

  assign w_last  = r_stage[ROM_LATENCY];
  assign w_hc    = w_last[41:31];
  assign w_vc    = w_last[30:20];
  assign w_hs    = w_last[19];
  assign w_vs    = w_last[18];
  assign w_hb    = w_last[17];
  assign w_vb    = w_last[16];
  assign w_rgb_d = w_last[15:4];
  assign w_en    = w_last[3];
  assign w_lcol  = w_last[2:0];

  // bit7 is the leftmost glyph column, so index with ~col.
  assign w_pix = char_pixels[~w_lcol];

  always_comb begin
    w_rgb = w_rgb_d;
    if (!(w_hb | w_vb) && w_en && w_pix)
      w_rgb = LETTER_COLOR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hc  <= '0;
      r_vc  <= '0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_hb  <= 1'b0;
      r_vb  <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_hc  <= w_hc;
      r_vc  <= w_vc;
      r_hs  <= w_hs;
      r_vs  <= w_vs;
      r_hb  <= w_hb;
      r_vb  <= w_vb;
      r_rgb <= w_rgb;
    end
  end

  assign vga_out_hcount = r_hc;
  assign vga_out_vcount = r_vc;
  assign vga_out_hsync  = r_hs;
  assign vga_out_vsync  = r_vs;
  assign vga_out_hblnk  = r_hb;
  assign vga_out_vblnk  = r_vb;
  assign vga_out_rgb    = r_rgb;

endmodule

// File: tb/tb_letters_draw.sv
// Bench for letters_draw at ROM latency 1 and 3, scored against
// a cycle-history frame model driven by mixed random and directed video.
module tb_letters_draw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] addr = '0;
  logic [10:0] hc = '0;
  logic [10:0] vc = '0;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic        hb = 1'b0;
  logic        vb = 1'b0;
  logic [11:0] rgb = '0;

  logic [7:0]  rom1, rom3a, rom3b, rom3c;

  logic [10:0] o1_hc, o1_vc, o3_hc, o3_vc;
  logic        o1_hs, o1_vs, o1_hb, o1_vb;
  logic        o3_hs, o3_vs, o3_hb, o3_vb;
  logic [11:0] o1_rgb, o3_rgb;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic [10:0] addr;
    logic        rst;
  } snap_t;

  snap_t hist[$];

  always #5 clk = ~clk;

  letters_draw #(.ROM_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .char_addr(addr), .char_pixels(rom1),
    .vga_in_hcount(hc), .vga_in_vcount(vc),
    .vga_in_hsync(hs), .vga_in_vsync(vs),
    .vga_in_hblnk(hb), .vga_in_vblnk(vb),
    .vga_in_rgb(rgb),
    .vga_out_hcount(o1_hc), .vga_out_vcount(o1_vc),
    .vga_out_hsync(o1_hs), .vga_out_vsync(o1_vs),
    .vga_out_hblnk(o1_hb), .vga_out_vblnk(o1_vb),
    .vga_out_rgb(o1_rgb)
  );

  letters_draw #(.ROM_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst),
    .char_addr(addr), .char_pixels(rom3c),
    .vga_in_hcount(hc), .vga_in_vcount(vc),
    .vga_in_hsync(hs), .vga_in_vsync(vs),
    .vga_in_hblnk(hb), .vga_in_vblnk(vb),
    .vga_in_rgb(rgb),
    .vga_out_hcount(o3_hc), .vga_out_vcount(o3_vc),
    .vga_out_hsync(o3_hs), .vga_out_vsync(o3_vs),
    .vga_out_hblnk(o3_hb), .vga_out_vblnk(o3_vb),
    .vga_out_rgb(o3_rgb)
  );

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    logic [7:0] t;
    if (a == 11'h313) return 8'h81;
    if (a == 11'h7F0 || a == 11'h000) return 8'hFF;
    t = a[7:0] * 8'd37;
    return t ^ {a[10:4], 1'b1};
  endfunction

  // Font ROM models: 1-cycle and 3-cycle read latency.
  always @(posedge clk) begin
    rom1  <= rom_fn(addr);
    rom3a <= rom_fn(addr);
    rom3b <= rom3a;
    rom3c <= rom3b;
  end

  initial forever begin
    snap_t s;
    @(posedge clk);
    s.hc = hc; s.vc = vc; s.hs = hs; s.vs = vs;
    s.hb = hb; s.vb = vb; s.rgb = rgb;
    s.addr = addr; s.rst = rst;
    hist.push_front(s);
    if (hist.size() > 8) void'(hist.pop_back());
  end

  // Output after edge n is the input seen at edge n-L, painted, provided
  // reset was high at all of the last L+1 edges and is high now.
  function automatic void model(input int lat,
                                output logic [25:0] ctl,
                                output logic [11:0] ergb);
    snap_t s;
    int    c;
    bit    pix;
    ctl  = '0;
    ergb = '0;
    if (!rst || hist.size() < lat + 1) return;
    for (int i = 0; i <= lat; i++)
      if (!hist[i].rst) return;
    s    = hist[lat];
    ctl  = {s.hc, s.vc, s.hs, s.vs, s.hb, s.vb};
    c    = ((int'(s.hc) - 4) % 8 + 8) % 8;
    pix  = ((rom_fn(s.addr) >> (7 - c)) & 8'd1) != 0;
    ergb = s.rgb;
    if (!(s.hb || s.vb) && (s.addr / 16) != 0 && pix)
      ergb = 12'hFFF;
  endfunction

  task automatic check_eq(input string tag,
                          input logic [63:0] obs,
                          input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)",
                  tag, obs, exp, $time);
  endtask

  initial forever begin
    logic [25:0] ctl;
    logic [11:0] er;
    @(negedge clk);
    if (chk_en) begin
      model(1, ctl, er);
      check_eq("l1_ctl", {o1_hc, o1_vc, o1_hs, o1_vs, o1_hb, o1_vb}, ctl);
      check_eq("l1_rgb", o1_rgb, er);
      model(3, ctl, er);
      check_eq("l3_ctl", {o3_hc, o3_vc, o3_hs, o3_vs, o3_hb, o3_vb}, ctl);
      check_eq("l3_rgb", o3_rgb, er);
    end
  end

  task automatic drive(input logic [10:0] h, input logic [10:0] v,
                       input logic [10:0] a, input logic [11:0] c,
                       input logic hbl);
    @(posedge clk);
    #1;
    hc   = h;
    vc   = v;
    addr = a;
    rgb  = c;
    hb   = hbl;
    vb   = (v >= 11'd768);
    hs   = (h >= 11'd1048 && h < 11'd1184);
    vs   = (v >= 11'd771 && v < 11'd777);
  endtask

  function automatic logic [10:0] rnd_addr();
    case ($urandom % 4)
      0:       return 11'h000;
      1:       return 11'h313;
      default: return 11'($urandom);
    endcase
  endfunction

  initial begin
    logic [10:0] vl [4] = '{11'd0, 11'd100, 11'd767, 11'd768};
    #2 rst = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 10; i++)
      drive(11'($urandom), 11'($urandom), rnd_addr(),
            12'($urandom), 1'($urandom));
    rst = 1'b1;
    foreach (vl[j])
      for (int h = 0; h < 1344; h++)
        drive(11'(h), vl[j], rnd_addr(), 12'($urandom),
              h >= 1024 || ($urandom % 16 == 0));
    for (int h = 0; h < 1344; h++)
      drive(11'(h), 11'd10, 11'h000, 12'h0A5, h >= 1024);
    for (int h = 276; h < 300; h++)
      drive(11'(h), 11'd20, (h >= 284 && h <= 291) ? 11'h313 : 11'h000,
            12'h123, 1'b0);
    for (int h = 1016; h < 1040; h++)
      drive(11'(h), 11'd21, 11'h7F0, 12'h456, h >= 1024);
    for (int h = 276; h < 300; h++) begin
      drive(11'(h), 11'd22, (h >= 280 && h <= 295) ? 11'h313 : 11'h7F0,
            12'h789, 1'b0);
      if (h == 284) rst = 1'b0;
      if (h == 287) rst = 1'b1;
    end
    for (int i = 0; i < 200; i++)
      drive(11'($urandom), 11'($urandom % 800), rnd_addr(),
            12'($urandom), 1'($urandom % 4 == 0));
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
